// File: rtl/serial_xfer_ctrl.sv
// Serial transfer controller: latch B, shift WIDTH bits of A in, latch C, shift WIDTH bits of C out.
// Latency: done pulses 2*WIDTH+1 cycles after start_a is accepted; busy is registered.
// Backpressure: none; load_b/start_a are one-cycle requests honoured only in IDLE/WAIT_A. Macro SXC_TIMEOUT_EN adds a WAIT_A abort.
module serial_xfer_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_b,
  input  logic start_a,
  output logic latch_b,
  output logic shift_a,
  output logic latch_c,
  output logic shift_c,
  output logic start_c,
  output logic busy,
  output logic done,
  output logic timeout_err
);

  localparam int MAXV = (WIDTH > TIMEOUT) ? WIDTH : TIMEOUT;
  localparam int CW   = $clog2(MAXV + 1);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
`ifdef SXC_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_A  = 2'd1,
    SHIFT_A = 2'd2,
    SEND_C  = 2'd3
  } state_t;

  state_t          state, stateNext;
  logic [CW-1:0]   cnt, cntNext;

  // State, counter and registered busy flag; busy tracks the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      busy  <= (stateNext != IDLE);
    end
  end

  // Next-state and counter update; any unexpected encoding falls back to IDLE
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (load_b) begin
          stateNext = WAIT_A;
          cntNext   = '0;
        end
      end
      WAIT_A: begin
        if (start_a) begin
          // The accept cycle is itself the first shift of A
          stateNext = SHIFT_A;
          cntNext   = CW'(1);
        end
`ifdef SXC_TIMEOUT_EN
        else if (cnt >= TIMEOUT_C) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CW'(1);
        end
`endif
      end
      SHIFT_A: begin
        if (cnt < WIDTH_C) begin
          cntNext = cnt + CW'(1);
        end else begin
          stateNext = SEND_C;
          cntNext   = '0;
        end
      end
      SEND_C: begin
        if (cnt < WIDTH_C) begin
          cntNext = cnt + CW'(1);
        end else begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Mealy strobes from state, cnt and inputs; all forced low while reset is held
  always_comb begin
    latch_b     = 1'b0;
    shift_a     = 1'b0;
    latch_c     = 1'b0;
    shift_c     = 1'b0;
    start_c     = 1'b0;
    done        = 1'b0;
    timeout_err = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          latch_b = load_b;
        end
        WAIT_A: begin
          shift_a = start_a;
`ifdef SXC_TIMEOUT_EN
          timeout_err = !start_a && (cnt >= TIMEOUT_C);
`endif
        end
        SHIFT_A: begin
          shift_a = (cnt < WIDTH_C);
          latch_c = !(cnt < WIDTH_C);
        end
        SEND_C: begin
          shift_c = (cnt < WIDTH_C);
          start_c = (cnt == '0);
          done    = !(cnt < WIDTH_C);
        end
        default: begin
          latch_b = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Testbench for serial_xfer_ctrl: WIDTH=4 and WIDTH=1 instances against a schedule-based reference.
// Each transfer is expanded into its per-cycle expected strobe pattern, then replayed and compared.
// Works with or without SXC_TIMEOUT_EN; the reference follows whichever build is compiled.
module tb_serial_xfer_ctrl;

  localparam int TO = 5;
`ifdef SXC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Expected-vector bit masks: {busy, timeout_err, done, start_c, shift_c, latch_c, shift_a, latch_b}
  localparam logic [7:0] M_LB = 8'h01, M_SA = 8'h02, M_LC = 8'h04, M_SC = 8'h08;
  localparam logic [7:0] M_ST = 8'h10, M_DN = 8'h20, M_TO = 8'h40, M_BY = 8'h80;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ldB = 1'b0, stA = 1'b0, ldB1 = 1'b0, stA1 = 1'b0;
  logic lb4, sa4, lc4, sc4, st4, by4, dn4, to4;
  logic lb1, sa1, lc1, sc1, st1, by1, dn1, to1;
  logic [7:0] obs4, obs1;

  int checks = 0;
  int errors = 0;

  bit         ldQ[$];
  bit         stQ[$];
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  serial_xfer_ctrl #(.WIDTH(4), .TIMEOUT(TO)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_b(ldB), .start_a(stA),
    .latch_b(lb4), .shift_a(sa4), .latch_c(lc4), .shift_c(sc4), .start_c(st4),
    .busy(by4), .done(dn4), .timeout_err(to4)
  );

  serial_xfer_ctrl #(.WIDTH(1), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_b(ldB1), .start_a(stA1),
    .latch_b(lb1), .shift_a(sa1), .latch_c(lc1), .shift_c(sc1), .start_c(st1),
    .busy(by1), .done(dn1), .timeout_err(to1)
  );

  assign obs4 = {by4, to4, dn4, st4, sc4, lc4, sa4, lb4};
  assign obs1 = {by1, to1, dn1, st1, sc1, lc1, sa1, lb1};

  function automatic bit rb(input bit en);
    return en ? bit'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic push(input bit ld, input bit st, input logic [7:0] e);
    ldQ.push_back(ld);
    stQ.push_back(st);
    expQ.push_back(e);
  endtask

  task automatic clear_q();
    ldQ.delete();
    stQ.delete();
    expQ.delete();
  endtask

  // Expand one transfer: gap idle cycles, load_b, w quiet WAIT_A cycles, then start_a (or a timeout)
  task automatic add_xfer(input int gap, input int w, input bit noise, input int width);
    for (int i = 0; i < gap; i++) push(1'b0, rb(1'b1), 8'h00);
    push(1'b1, rb(1'b1), M_LB);
    if (TO_EN && w > TO) begin
      for (int k = 0; k < TO; k++) push(rb(noise), 1'b0, M_BY);
      push(rb(noise), 1'b0, M_BY | M_TO);
    end else begin
      for (int k = 0; k < w; k++) push(rb(noise), 1'b0, M_BY);
      push(rb(noise), 1'b1, M_BY | M_SA);
      for (int j = 1; j < width; j++) push(rb(noise), rb(noise), M_BY | M_SA);
      push(rb(noise), rb(noise), M_BY | M_LC);
      for (int j = 0; j < width; j++)
        push(rb(noise), rb(noise), M_BY | M_SC | ((j == 0) ? M_ST : 8'h00));
      push(rb(noise), rb(noise), M_BY | M_DN);
    end
  endtask

  // Replay up to n queued cycles into one DUT and compare every output each cycle
  task automatic play(input string name, input bit sel, input int n);
    int idx = 0;
    while (ldQ.size() > 0 && idx < n) begin
      bit ld, st;
      logic [7:0] e, o;
      ld = ldQ.pop_front();
      st = stQ.pop_front();
      e  = expQ.pop_front();
      @(posedge clk);
      #1;
      if (sel) begin
        ldB1 = ld; stA1 = st;
      end else begin
        ldB = ld; stA = st;
      end
      @(negedge clk);
      o = sel ? obs1 : obs4;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    ldB = 1'b1; stA = 1'b1; ldB1 = 1'b1; stA1 = 1'b1;
    #2;
    checks++;
    if ({obs4, obs1} !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: got %b/%b expected 0/0", obs4, obs1);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({obs4, obs1} !== 16'h0) begin
      errors++;
      $display("FAIL reset_held: got %b/%b expected 0/0", obs4, obs1);
    end
    ldB = 1'b0; stA = 1'b0; ldB1 = 1'b0; stA1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({obs4, obs1} !== 16'h0) begin
      errors++;
      $display("FAIL reset_release: got %b/%b expected 0/0", obs4, obs1);
    end
  endtask

  task automatic test_directed();
    clear_q();
    add_xfer(0, 2, 1'b0, 4);
    push(1'b0, 1'b0, 8'h00);
    play("directed_w4", 1'b0, 1000);
  endtask

  task automatic test_width1();
    clear_q();
    add_xfer(0, 1, 1'b0, 1);
    push(1'b0, 1'b0, 8'h00);
    add_xfer(0, 0, 1'b1, 1);
    push(1'b0, 1'b0, 8'h00);
    play("width1", 1'b1, 1000);
  endtask

  task automatic test_noise();
    clear_q();
    add_xfer(0, 2, 1'b1, 4);
    push(1'b0, 1'b0, 8'h00);
    play("input_noise", 1'b0, 1000);
  endtask

  task automatic test_back_to_back();
    clear_q();
    for (int t = 0; t < 4; t++) add_xfer(0, $urandom_range(0, 3), 1'b1, 4);
    push(1'b0, 1'b0, 8'h00);
    play("back_to_back", 1'b0, 1000);
  endtask

  task automatic test_timeout();
    clear_q();
    add_xfer(0, TO + 1, 1'b0, 4);
    add_xfer(0, TO, 1'b0, 4);
    add_xfer(1, TO + 3, 1'b1, 4);
    push(1'b0, 1'b0, 8'h00);
    play("timeout_bound", 1'b0, 1000);
  endtask

  task automatic test_random();
    clear_q();
    for (int t = 0; t < 25; t++)
      add_xfer($urandom_range(0, 3), $urandom_range(0, 8), bit'($urandom_range(0, 1)), 4);
    push(1'b0, 1'b0, 8'h00);
    play("random_w4", 1'b0, 100000);
    clear_q();
    for (int t = 0; t < 15; t++)
      add_xfer($urandom_range(0, 3), $urandom_range(0, 8), bit'($urandom_range(0, 1)), 1);
    push(1'b0, 1'b0, 8'h00);
    play("random_w1", 1'b1, 100000);
  endtask

  // Abort in SEND_C at cnt=2, then confirm silence and a clean restart
  task automatic test_reset_mid();
    clear_q();
    add_xfer(0, 0, 1'b0, 4);
    play("pre_reset", 1'b0, 9);
    clear_q();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs4 !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_async: got %b expected %b", obs4, 8'h00);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs4 !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_held: got %b expected %b", obs4, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) push(1'b0, 1'b0, 8'h00);
    add_xfer(0, 1, 1'b0, 4);
    push(1'b0, 1'b0, 8'h00);
    play("post_reset", 1'b0, 1000);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_width1();
    test_noise();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_xfer_ctrl.md
SERIAL_XFER_CTRL -- requirements
Module: serial_xfer_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, bits per word shifted in on A and out on C; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 16, WAIT_A cycles tolerated before abort; used only with SXC_TIMEOUT_EN; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port load_b  input  1  request to latch operand B.
REQ-006 Port start_a  input  1  request to start serial intake of A.
REQ-007 Port latch_b  output  1  load enable for the B register.
REQ-008 Port shift_a  output  1  shift enable for the A shift register.
REQ-009 Port latch_c  output  1  load enable for the C result register.
REQ-010 Port shift_c  output  1  shift enable for the C shift register.
REQ-011 Port start_c  output  1  marks the first shift_c cycle of a word.
REQ-012 Port busy  output  1  high whenever state is not IDLE.
REQ-013 Port done  output  1  one-cycle pulse when a transfer completes.
REQ-014 Port timeout_err  output  1  one-cycle pulse on WAIT_A abort.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_A, SHIFT_A, SEND_C, plus a counter cnt of width ceil(log2(max(WIDTH,TIMEOUT)+1)).
REQ-016 latch_b, shift_a, latch_c, shift_c, start_c, done and timeout_err SHALL be Mealy outputs (current state, cnt, inputs), default 0 in every state.
REQ-017 IDLE: load_b=1 -> latch_b=1 that cycle, next WAIT_A, cnt<=0; otherwise stay IDLE.
REQ-018 WAIT_A: start_a=1 -> shift_a=1 that cycle, cnt<=1, next SHIFT_A; otherwise stay in WAIT_A.
REQ-019 SHIFT_A: cnt<WIDTH -> shift_a=1, cnt<=cnt+1; cnt==WIDTH -> latch_c=1, cnt<=0, next SEND_C.
REQ-020 SEND_C: cnt<WIDTH -> shift_c=1, cnt<=cnt+1, start_c=1 only when cnt==0; cnt==WIDTH -> done=1, cnt<=0, next IDLE.
REQ-021 Per word: exactly WIDTH shift_a cycles, one latch_c cycle, WIDTH shift_c cycles, then one done cycle.
REQ-022 Latency: done asserts 2*WIDTH+1 cycles after the cycle start_a is accepted.
REQ-023 WIDTH=1: the accept cycle is the only shift_a cycle, and SHIFT_A goes straight to latch_c.
REQ-024 load_b is ignored outside IDLE, and start_a is ignored outside WAIT_A; neither input alters an ongoing transfer.
REQ-025 load_b and start_a both high in IDLE: only load_b acts; start_a is not remembered.
REQ-026 busy SHALL be a registered decode of state != IDLE and SHALL be low in the done cycle's following cycle.
REQ-027 No output SHALL glitch to 1 from an illegal state; illegal state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, cnt=0 and busy=0, regardless of clk.
REQ-029 While rst_n is low, all outputs SHALL be 0, including the Mealy outputs.
REQ-030 Reset asserted mid-transfer SHALL abandon the word with no done or timeout_err pulse; after release the block waits for load_b.

Configuration
REQ-031 Macro SXC_TIMEOUT_EN defined: in WAIT_A, cnt counts cycles without start_a.
REQ-032 With SXC_TIMEOUT_EN, when cnt reaches TIMEOUT with start_a=0, timeout_err=1 that cycle, cnt<=0 and next is IDLE.
REQ-033 With SXC_TIMEOUT_EN, start_a=1 in the cycle cnt==TIMEOUT wins: it is accepted and no timeout_err pulse occurs.
REQ-034 Macro undefined: WAIT_A waits indefinitely, the TIMEOUT parameter is ignored, and timeout_err is tied to 0.

Verification
REQ-035 WIDTH=4; load_b at cycle 0, start_a at cycle 3 -> latch_b@0; shift_a@3-6; latch_c@7; shift_c@8-11 with start_c@8 only; done@12; busy@1-12, low@13.
REQ-036 WIDTH=1 -> shift_a one cycle; latch_c next cycle; shift_c plus start_c next; done next.
REQ-037 WIDTH=4; load_b and start_a toggled throughout SHIFT_A and SEND_C -> pulse pattern identical to REQ-035 and no extra latch_b.
REQ-038 Reset pulse during SEND_C at cnt=2 -> all outputs 0 immediately; no done; a new load_b after release -> normal transfer.
REQ-039 SXC_TIMEOUT_EN, TIMEOUT=5; load_b then no start_a -> timeout_err exactly 5 cycles after entering WAIT_A, then IDLE.
REQ-040 SXC_TIMEOUT_EN; start_a arrives in the cnt==TIMEOUT cycle -> start_a accepted and no timeout_err.
